// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select of a shared 4:1 mux
//
// Ports:
//   clk_in       rising-edge clock
//   rst_in       synchronous active-high reset
//   req_in[3:0]  request per requester; bit i asks for mux input i
//   gnt_out[3:0] registered one-hot grant, or all zero when idle
//   sel_out[1:0] registered index of the current or last owner; feeds the mux select
//   busy_out     high while a grant is active
//   timeout_out  one-cycle pulse when the current owner is forcibly released
//
// Optional feature: define MUX4_ARB_TIMEOUT_EN to limit how long an owner may
// hold the grant while others wait (HOLD_MAX cycles, counter CNT_W bits wide).
// Without it the grant is held until the owner drops its request.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] req_in,
    output logic [3:0] gnt_out,
    output logic [1:0] sel_out,
    output logic       busy_out,
    output logic       timeout_out
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;

    logic [3:0] arb_req;
    logic [1:0] arb_start;
    logic       arb_en;
    logic       release_en;
    logic [2:0] pick;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
    // Iterating from the far end lets the nearest candidate overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef MUX4_ARB_TIMEOUT_EN
    // cnt is the number of completed cycles the owner has held the grant, so the
    // grant has been visible for cnt+1 cycles when it reaches HOLD_MAX-1.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hold_expired;
    logic             others_pending;

    assign hold_expired   = (cnt >= CNT_W'(HOLD_MAX - 1));
    assign others_pending = |(req_in & ~gnt_out);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (HOLD_MAX > 0) && (CNT_W > 0);
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt_out;
        sel_nxt     = sel_out;
        busy_nxt    = busy_out;
        timeout_nxt = 1'b0;
        arb_req     = 4'b0000;
        arb_start   = ptr;
        arb_en      = 1'b0;
        release_en  = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
        cnt_nxt     = cnt;
`endif
        case (state)
            IDLE: begin
                arb_req   = req_in;
                arb_start = ptr;
                arb_en    = 1'b1;
            end
            GRANT: begin
                if (!req_in[sel_out]) begin
                    // Owner dropped: re-arbitrate this cycle so there is no idle bubble.
                    release_en = 1'b1;
                    ptr_nxt    = sel_out + 2'd1;
                    arb_req    = req_in;
                    arb_start  = sel_out + 2'd1;
                    arb_en     = 1'b1;
                end
`ifdef MUX4_ARB_TIMEOUT_EN
                else if (hold_expired && others_pending) begin
                    // Owner still requesting, so mask it out; another winner always exists.
                    ptr_nxt     = sel_out + 2'd1;
                    arb_req     = req_in & ~gnt_out;
                    arb_start   = sel_out + 2'd1;
                    arb_en      = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (cnt < CNT_W'(HOLD_MAX)) begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        pick = rr_pick(arb_req, arb_start);
        if (arb_en && pick[2]) begin
            gnt_nxt   = 4'b0001 << pick[1:0];
            sel_nxt   = pick[1:0];
            busy_nxt  = 1'b1;
            state_nxt = GRANT;
`ifdef MUX4_ARB_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
        end else if (release_en) begin
            // sel_out keeps the last owner so the mux output stays stable while idle.
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            gnt_out     <= 4'b0000;
            sel_out     <= 2'd0;
            busy_out    <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gnt_out     <= gnt_nxt;
            sel_out     <= sel_nxt;
            busy_out    <= busy_nxt;
            timeout_out <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard testbench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int HOLD_MAX = 8;
    localparam int CNT_W    = 4;

    logic       clk_in;
    logic       rst_in;
    logic [3:0] req_in;
    logic [3:0] gnt_out;
    logic [1:0] sel_out;
    logic       busy_out;
    logic       timeout_out;

    mux4_rr_arbiter #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .req_in     (req_in),
        .gnt_out    (gnt_out),
        .sel_out    (sel_out),
        .busy_out   (busy_out),
        .timeout_out(timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Expected {gnt[3:0], sel[1:0], busy, timeout} after each edge.
    logic [7:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 0;

    // Reference model: who owns the grant, for how many visible cycles, and
    // where the next round-robin scan starts.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 0;

    function automatic int scan(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] q);
        int w;
        m_to = 0;
        if (r) begin
            m_owner = -1;
            m_sel   = 0;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            w = scan(q, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_held  = 1;
            end
        end else if (!q[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            w = scan(q, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
            logic [3:0] others;
            others = q;
            others[m_owner] = 1'b0;
            if (m_held >= HOLD_MAX && others != 4'b0000) begin
                m_ptr   = (m_owner + 1) % 4;
                w       = scan(others, m_ptr);
                m_owner = w;
                m_sel   = w;
                m_held  = 1;
                m_to    = 1;
            end else begin
                m_held++;
            end
`else
            m_held++;
`endif
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q);
        logic [3:0] eg;
        @(negedge clk_in);
        rst_in = r;
        req_in = q;
        model_step(r, q);
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        sb.push_back({eg, 2'(m_sel), (m_owner >= 0), m_to});
        running = 1;
    endtask

    // Monitor: outputs are valid every cycle, so compare once per edge.
    initial begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        forever begin
            @(posedge clk_in);
            #1;
            if (running) begin
                n_checks++;
                act_v = {gnt_out, sel_out, busy_out, timeout_out};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_underflow t=%0t actual=%b", $time, act_v);
                end else begin
                    exp_v = sb.pop_front();
                    if (act_v !== exp_v) begin
                        n_fail++;
                        $display("FAIL outputs t=%0t gnt=%b/%b sel=%b/%b busy=%b/%b timeout=%b/%b (actual/required)",
                                 $time, act_v[7:4], exp_v[7:4], act_v[3:2], exp_v[3:2],
                                 act_v[1], exp_v[1], act_v[0], exp_v[0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] q;
        int wait_cnt;
        rst_in = 1'b1;
        req_in = 4'b0000;

        // Reset with all requests, then first grant goes to requester 0.
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1111);
        for (int i = 0; i < 2; i++) drive(1'b0, 4'b0000);

        // Single requester, then drop; sel must hold while idle.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0100);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000);

        // All requesting; each owner drops its bit after two granted cycles.
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 24; i++) begin
            q = 4'b1111;
            if (m_owner >= 0 && m_held == 2) q[m_owner] = 1'b0;
            drive(1'b0, q);
        end

        // Two requesters held constant: timeout alternation or indefinite hold.
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 40; i++) drive(1'b0, 4'b0011);

        // Lone requester held: never times out.
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 20; i++) drive(1'b0, 4'b0001);

        // Reset mid-grant after the pointer has moved.
        drive(1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0100);
        drive(1'b1, 4'b1111);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1111);

        // Randomized traffic with occasional owner drops and resets.
        q = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) q = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) q[m_owner] = 1'b0;
            drive(($urandom_range(0, 59) == 0), q);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(negedge clk_in);
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
        running = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 mux datapath among four requesters. Each requester raises a request line. The block grants one requester at a time and drives the mux select so that requester's data reaches `y_out`. An optional hold-timeout forces fairness when an owner keeps its request asserted.

## Interface

Parameters:
- `HOLD_MAX`, default 8: maximum consecutive grant cycles before a forced release (timeout build only). Must be ≥ 1.
- `CNT_W`, default 4: hold-counter width. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- `clk_in`, input, 1: single clock; all logic is on the rising edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `req_in`, input, 4: request per requester; bit i requests mux input `a_in[i]`.
- `gnt_out`, output, 4: one-hot grant, or all zero.
- `sel_out`, output, 2: binary index of the current or last owner; connects to the mux `sel_in`.
- `busy_out`, output, 1: high while any grant is active.
- `timeout_out`, output, 1: one-cycle pulse on a forced release.

## Operation

- All outputs are registered.
- Reset values:
  - `gnt_out` = 0000, `sel_out` = 00, `busy_out` = 0, `timeout_out` = 0.
  - Round-robin pointer `ptr` = 0, hold counter = 0, state = IDLE.
- **IDLE state:**
  - With `req_in` ≠ 0, select the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - Next cycle: `gnt_out` = one-hot of the winner, `sel_out` = winner index, `busy_out` = 1. Go to GRANT.
- **GRANT state:**
  - While `req_in[owner]` = 1 and no timeout occurs, hold the grant and increment the counter.
  - Release: on the cycle `req_in[owner]` is sampled 0, set `ptr` = owner+1 mod 4.
    - If other requests are pending, arbitrate among them in the same cycle. The new grant appears on the next edge, with no idle bubble.
    - Otherwise `gnt_out` = 0, `busy_out` = 0, go to IDLE.
  - The counter resets to 0 on every new grant.
- `sel_out` holds the last owner's index while idle. The mux output therefore never glitches between grants.
- Requests that rise or fall while not owned have no effect until the next arbitration.
- Simultaneous release and new requests: the arbitration sees the current-cycle `req_in` value.
- Reset mid-grant: outputs return to reset values on the next edge; `ptr` returns to 0.

## Timing

- Request-to-grant latency: `req_in` sampled high at edge N gives `gnt_out` valid after edge N+1 (1 cycle).
- Release latency: owner request sampled low at edge M:
  - `gnt_out[owner]` is low after edge M+1.
  - The next owner's grant is high after the same edge M+1.
- `timeout_out` is high in exactly the cycle in which the new grant first appears.
- Maximum wait for any continuously requesting input (timeout build): 3 × HOLD_MAX + 3 cycles.

## Configuration

Macro: `MUX4_ARB_TIMEOUT_EN`.
- **Defined:**
  - When the owner has held the grant for HOLD_MAX cycles and any other `req_in` bit is set, the grant is forcibly released.
  - Re-arbitration happens exactly as for a normal release, with `ptr` = owner+1, and `timeout_out` pulses.
  - If no other requester is pending, the owner keeps the grant and the counter saturates at HOLD_MAX.
- **Undefined:**
  - No counter is implemented; the grant holds until the owner drops its request.
  - `timeout_out` is tied to 0.
  - `HOLD_MAX` and `CNT_W` are unused.

## Test plan

1. Hold `rst_in`=1 for 2 cycles with `req_in`=1111.
   -> All outputs stay at reset values.
   -> One cycle after reset release: `gnt_out`=0001, `sel_out`=00, `busy_out`=1.
2. Drive `req_in`=0100 for 3 cycles, then 0000.
   -> `gnt_out`=0100 and `sel_out`=10 starting one cycle after the request.
   -> After the drop: `gnt_out`=0000, `busy_out`=0, `sel_out` stays 10.
3. Drive `req_in`=1111, with each owner dropping its bit for one cycle after 2 cycles of grant.
   -> Grant order 0001, 0010, 0100, 1000, 0001, with no idle cycles between grants.
4. Timeout build, `HOLD_MAX`=8, `req_in`=0011 held constant.
   -> `gnt_out`=0001 for 8 cycles, `timeout_out` pulses, then `gnt_out`=0010 for 8 cycles, alternating.
   -> Non-timeout build: `gnt_out`=0001 indefinitely and `timeout_out` stays 0.
5. Timeout build, `req_in`=0001 only, held for 20 cycles.
   -> `gnt_out`=0001 throughout; no `timeout_out` pulse.
6. While `gnt_out`=0100 (`ptr` advanced), assert `rst_in` for 1 cycle with `req_in`=1111.
   -> Next cycle all outputs are 0.
   -> After reset release: `gnt_out`=0001.
